// File: rtl/compress.sv
// -----------------------------------------------------------------------------
// compress -- BLAKE2b compression function F
//
// Runs 12 rounds x 8 G-steps through a single time-shared mix datapath, then
// folds the 16-word work vector back into the chaining value.
//
// Parameters
//   MIX_LATENCY  cycles the mix inputs are held before v_out is taken (1..4)
//
// Ports
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   abort      in   1     job abort (only when COMPRESS_ABORT_EN is defined)
//   in_valid   in   1     h_in/m/t/last valid
//   in_ready   out  1     block can accept a job (IDLE)
//   h_in       in   512   chaining value, h[i] = h_in[i*64+:64]
//   m          in   1024  message block, m[i] = m[i*64+:64]
//   t          in   128   byte offset counter
//   last       in   1     final-block flag
//   out_valid  out  1     h_out valid
//   out_ready  in   1     consumer takes h_out
//   h_out      out  512   new chaining value
//
// Configuration macro
//   COMPRESS_ABORT_EN  adds the abort input; abort outside IDLE returns to
//                      IDLE on the next edge without producing an output.
// -----------------------------------------------------------------------------
module compress #(
    parameter int MIX_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef COMPRESS_ABORT_EN
    input  logic          abort,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [511:0]  h_in,
    input  logic [1023:0] m,
    input  logic [127:0]  t,
    input  logic          last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [511:0]  h_out
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_GSTEP = 3'd2;
    localparam logic [2:0] ST_FINAL = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Last cycle of the hold window in which the mix result is committed.
    localparam logic [1:0] WAIT_LAST = 2'(MIX_LATENCY - 1);

    // BLAKE2b initialisation vector
    function automatic logic [63:0] iv_word(input logic [2:0] idx);
        logic [63:0] w;
        case (idx)
            3'd0:    w = 64'h6a09e667f3bcc908;
            3'd1:    w = 64'hbb67ae8584caa73b;
            3'd2:    w = 64'h3c6ef372fe94f82b;
            3'd3:    w = 64'ha54ff53a5f1d36f1;
            3'd4:    w = 64'h510e527fade682d1;
            3'd5:    w = 64'h9b05688c2b3e6c1f;
            3'd6:    w = 64'h1f83d9abfb41bd6b;
            3'd7:    w = 64'h5be0cd19137e2179;
            default: w = 64'h0;
        endcase
        return w;
    endfunction

    // Message schedule ROM: nibble k of a row is sigma[row][k].
    function automatic logic [63:0] sigma_row(input logic [3:0] row);
        logic [63:0] r;
        case (row)
            4'd0:    r = 64'hFEDCBA9876543210;
            4'd1:    r = 64'h357B20C16DF984AE;
            4'd2:    r = 64'h491763EADF250C8B;
            4'd3:    r = 64'h8F04A562EBCD1397;
            4'd4:    r = 64'hD386CB1EFA427509;
            4'd5:    r = 64'h91EF57D438B0A6C2;
            4'd6:    r = 64'hB8293670A4DEF15C;
            4'd7:    r = 64'hA2684F05931CE7BD;
            4'd8:    r = 64'h5A417D2C803B9EF6;
            4'd9:    r = 64'h0DC3E9BF5167482A;
            default: r = 64'hFEDCBA9876543210;
        endcase
        return r;
    endfunction

    // G function; returns {d, c, b, a}. All additions wrap at 64 bits.
    function automatic logic [255:0] g_mix(input logic [63:0] a_i, input logic [63:0] b_i,
                                           input logic [63:0] c_i, input logic [63:0] d_i,
                                           input logic [63:0] x_i, input logic [63:0] y_i);
        logic [63:0] a_v, b_v, c_v, d_v, tmp_v;
        a_v   = a_i + b_i + x_i;
        tmp_v = d_i ^ a_v;
        d_v   = {tmp_v[31:0], tmp_v[63:32]};
        c_v   = c_i + d_v;
        tmp_v = b_i ^ c_v;
        b_v   = {tmp_v[23:0], tmp_v[63:24]};
        a_v   = a_v + b_v + y_i;
        tmp_v = d_v ^ a_v;
        d_v   = {tmp_v[15:0], tmp_v[63:16]};
        c_v   = c_v + d_v;
        tmp_v = b_v ^ c_v;
        b_v   = {tmp_v[62:0], tmp_v[63]};
        return {d_v, c_v, b_v, a_v};
    endfunction

    logic [2:0]        state_q, state_d;
    logic [511:0]      h_q, h_d;
    logic [1023:0]     m_q, m_d;
    logic [127:0]      t_q, t_d;
    logic              last_q, last_d;
    logic [15:0][63:0] v_q, v_d;
    logic [3:0]        round_q, round_d;
    logic [2:0]        step_q, step_d;
    logic [1:0]        wait_q, wait_d;
    logic [511:0]      h_out_q, h_out_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;

    logic              abort_s;
    logic [3:0]        round_mod_s;
    logic [63:0]       sigma_s;
    logic [1:0]        lane_b_s, lane_c_s, lane_d_s;
    logic [3:0]        idx_a_s, idx_b_s, idx_c_s, idx_d_s;
    logic [3:0]        x_idx_s, y_idx_s;
    logic [63:0]       x_s, y_s;
    logic [255:0]      mix_s;
    logic [15:0][63:0] v_out_s;

`ifdef COMPRESS_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Mix operand selection: column steps 0..3, diagonal steps 4..7 rotate lanes.
    always_comb begin
        if (round_q >= 4'd10) begin
            round_mod_s = round_q - 4'd10;
        end else begin
            round_mod_s = round_q;
        end
        sigma_s = sigma_row(round_mod_s);
        if (step_q[2]) begin
            lane_b_s = step_q[1:0] + 2'd1;
            lane_c_s = step_q[1:0] + 2'd2;
            lane_d_s = step_q[1:0] + 2'd3;
        end else begin
            lane_b_s = step_q[1:0];
            lane_c_s = step_q[1:0];
            lane_d_s = step_q[1:0];
        end
        idx_a_s = {2'b00, step_q[1:0]};
        idx_b_s = {2'b01, lane_b_s};
        idx_c_s = {2'b10, lane_c_s};
        idx_d_s = {2'b11, lane_d_s};
        x_idx_s = sigma_s[{step_q, 3'b000} +: 4];
        y_idx_s = sigma_s[{step_q, 3'b100} +: 4];
        x_s     = m_q[{x_idx_s, 6'b000000} +: 64];
        y_s     = m_q[{y_idx_s, 6'b000000} +: 64];
        mix_s   = g_mix(v_q[idx_a_s], v_q[idx_b_s], v_q[idx_c_s], v_q[idx_d_s], x_s, y_s);
        v_out_s = v_q;
        v_out_s[idx_a_s] = mix_s[63:0];
        v_out_s[idx_b_s] = mix_s[127:64];
        v_out_s[idx_c_s] = mix_s[191:128];
        v_out_s[idx_d_s] = mix_s[255:192];
    end

    // Job sequencing FSM and next-state datapath.
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        m_d         = m_q;
        t_d         = t_q;
        last_d      = last_q;
        v_d         = v_q;
        round_d     = round_q;
        step_d      = step_q;
        wait_d      = wait_q;
        h_out_d     = h_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    h_d     = h_in;
                    m_d     = m;
                    t_d     = t;
                    last_d  = last;
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                for (int i = 0; i < 8; i++) begin
                    v_d[i]     = h_q[i*64 +: 64];
                    v_d[i + 8] = iv_word(3'(i));
                end
                v_d[12] = v_d[12] ^ t_q[63:0];
                v_d[13] = v_d[13] ^ t_q[127:64];
                if (last_q) begin
                    v_d[14] = ~v_d[14];
                end else begin
                    v_d[14] = iv_word(3'd6);
                end
                round_d = 4'd0;
                step_d  = 3'd0;
                wait_d  = 2'd0;
                state_d = ST_GSTEP;
            end
            ST_GSTEP: begin
                if (wait_q == WAIT_LAST) begin
                    v_d    = v_out_s;
                    wait_d = 2'd0;
                    if (step_q == 3'd7) begin
                        step_d = 3'd0;
                        if (round_q == 4'd11) begin
                            state_d = ST_FINAL;
                        end else begin
                            round_d = round_q + 4'd1;
                        end
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    h_out_d[i*64 +: 64] = h_q[i*64 +: 64] ^ v_q[i] ^ v_q[i + 8];
                end
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        // Abort outranks everything, including the DONE handshake.
        if (abort_s && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            h_out_d     = h_out_q;
        end else begin
            state_d = state_d;
        end
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            h_q         <= 512'd0;
            m_q         <= 1024'd0;
            t_q         <= 128'd0;
            last_q      <= 1'b0;
            v_q         <= '0;
            round_q     <= 4'd0;
            step_q      <= 3'd0;
            wait_q      <= 2'd0;
            h_out_q     <= 512'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            m_q         <= m_d;
            t_q         <= t_d;
            last_q      <= last_d;
            v_q         <= v_d;
            round_q     <= round_d;
            step_q      <= step_d;
            wait_q      <= wait_d;
            h_out_q     <= h_out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign h_out     = h_out_q;

endmodule

// File: tb/tb_compress.sv
// -----------------------------------------------------------------------------
// tb_compress -- scoreboard bench for the BLAKE2b compression block.
// Expected chaining values come from the published BLAKE2b-512 digests of
// "abc" and "" and from a behavioural model of F for random blocks.
// -----------------------------------------------------------------------------
module tb_compress;

    localparam int LAT = 1;

    localparam logic [511:0] ABC_DIG = 512'hba80a53f981c4d0d6a2797b69f12f6e94c212f14685ac4b74b12bb6fdbffa2d17d87c5392aab792dc252d5de4533cc9518d38aa8dbf1925ab92386edd4009923;
    localparam logic [511:0] EMPTY_DIG = 512'h786a02f742015903c6c6fd852552d272912f4740e15847618a86e217f71f5419d25e1031afee585313896444934eb04b903a685b1448b755d56f701afe9be2ce;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [511:0]  h_in;
    logic [1023:0] m;
    logic [127:0]  t;
    logic          last;
    logic          out_valid;
    logic          out_ready;
    logic [511:0]  h_out;

    logic [511:0]  exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            accept_cyc = 0;

    typedef logic [15:0][63:0] work_t;

    logic [63:0] iv_tb [8] = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
                               64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                               64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    int sigma_tb [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}};
    int ga_tb [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int gb_tb [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
    int gc_tb [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
    int gd_tb [8] = '{12, 13, 14, 15, 15, 12, 13, 14};

    compress #(.MIX_LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef COMPRESS_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .h_in      (h_in),
        .m         (m),
        .t         (t),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .h_out     (h_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] rotr_tb(input logic [63:0] w, input int n);
        return (w >> n) | (w << (64 - n));
    endfunction

    function automatic work_t g_tb(input work_t w, input int a, input int b, input int c,
                                   input int d, input logic [63:0] x, input logic [63:0] y);
        w[a] = w[a] + w[b] + x;
        w[d] = rotr_tb(w[d] ^ w[a], 32);
        w[c] = w[c] + w[d];
        w[b] = rotr_tb(w[b] ^ w[c], 24);
        w[a] = w[a] + w[b] + y;
        w[d] = rotr_tb(w[d] ^ w[a], 16);
        w[c] = w[c] + w[d];
        w[b] = rotr_tb(w[b] ^ w[c], 63);
        return w;
    endfunction

    function automatic logic [511:0] model_f(input logic [511:0] hh, input logic [1023:0] mm,
                                             input logic [127:0] tt, input logic lst);
        work_t v;
        logic [511:0] r;
        int s;
        for (int i = 0; i < 8; i++) begin
            v[i]     = hh[i*64 +: 64];
            v[i + 8] = iv_tb[i];
        end
        v[12] = v[12] ^ tt[63:0];
        v[13] = v[13] ^ tt[127:64];
        if (lst) v[14] = ~v[14];
        for (int rd = 0; rd < 12; rd++) begin
            s = rd % 10;
            for (int j = 0; j < 8; j++) begin
                v = g_tb(v, ga_tb[j], gb_tb[j], gc_tb[j], gd_tb[j],
                         mm[sigma_tb[s][2*j]*64 +: 64], mm[sigma_tb[s][2*j+1]*64 +: 64]);
            end
        end
        for (int i = 0; i < 8; i++) r[i*64 +: 64] = hh[i*64 +: 64] ^ v[i] ^ v[i + 8];
        return r;
    endfunction

    // Digest bytes in output order -> h_out layout (little-endian words).
    function automatic logic [511:0] digest_to_h(input logic [511:0] d);
        logic [511:0] r;
        for (int k = 0; k < 64; k++) r[k*8 +: 8] = d[511 - 8*k -: 8];
        return r;
    endfunction

    function automatic logic [511:0] param_h();
        logic [511:0] r;
        for (int i = 0; i < 8; i++) r[i*64 +: 64] = iv_tb[i];
        r[63:0] = r[63:0] ^ 64'h0000_0000_0101_0040;
        return r;
    endfunction

    // Offer a job from a negedge; push the expected result when it is accepted.
    task automatic send(input logic [511:0] hh, input logic [1023:0] mm, input logic [127:0] tt,
                        input logic ll, input logic [511:0] expv, input bit hold);
        bit got;
        got      = 1'b0;
        h_in     = hh;
        m        = mm;
        t        = tt;
        last     = ll;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            if (in_ready) got = 1'b1;
            @(negedge clk);
        end
        if (got) begin
            exp_q.push_back(expv);
            accept_cyc = cyc;
        end else begin
            check_eq("accept_timeout", 512'(in_ready), 512'(1'b1));
        end
        if (!hold) in_valid = 1'b0;
    endtask

    // Wait for a result, optionally stall it, then pop and compare at handshake.
    task automatic receive(input string tag, input int stall, input bit chk_lat);
        bit seen;
        logic [511:0] first;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            check_eq({tag, "_timeout"}, 512'(out_valid), 512'(1'b1));
        end else begin
            if (chk_lat) check_eq({tag, "_latency"}, 512'(cyc - accept_cyc), 512'(2 + 96*LAT));
            first = h_out;
            for (int i = 0; i < stall; i++) begin
                out_ready = 1'b0;
                in_valid  = ~in_valid;
                h_in      = {16{$urandom()}};
                @(negedge clk);
                check_eq({tag, "_stall_valid"}, 512'(out_valid), 512'(1'b1));
                check_eq({tag, "_stall_hold"}, h_out, first);
                check_eq({tag, "_stall_ready"}, 512'(in_ready), 512'(1'b0));
            end
            if (stall > 0) in_valid = 1'b0;
            out_ready = 1'b1;
            if (exp_q.size() == 0) check_eq({tag, "_unexpected"}, 512'(out_valid), 512'(1'b0));
            else check_eq(tag, h_out, exp_q.pop_front());
            @(negedge clk);
            out_ready = 1'b0;
            check_eq({tag, "_drop"}, 512'(out_valid), 512'(1'b0));
        end
    endtask

    initial begin
        logic [511:0]  rh;
        logic [1023:0] rm;
        logic [127:0]  rt;
        logic          rl;
        logic [511:0]  m0;
        bit            seen;

        rst_n     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        h_in      = 512'd0;
        m         = 1024'd0;
        t         = 128'd0;
        last      = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 512'(in_ready), 512'(1'b0));
        check_eq("rst_out_valid", 512'(out_valid), 512'(1'b0));
        check_eq("rst_h_out", h_out, 512'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", 512'(in_ready), 512'(1'b1));

        // Empty message with 20 cycles of backpressure
        send(param_h(), 1024'd0, 128'd0, 1'b1, digest_to_h(EMPTY_DIG), 1'b0);
        receive("empty", 20, 1'b1);

        // "abc"
        m0 = 512'd0;
        m0[63:0] = 64'h0000_0000_0063_6261;
        send(param_h(), {512'd0, m0}, 128'd3, 1'b1, digest_to_h(ABC_DIG), 1'b0);
        receive("abc", 0, 1'b1);

        // Random blocks against the model
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 16; w++) rh[w*32 +: 32] = $urandom();
            for (int w = 0; w < 32; w++) rm[w*32 +: 32] = $urandom();
            for (int w = 0; w < 4; w++) rt[w*32 +: 32] = (k == 2) ? $urandom() : 32'd0;
            if (k != 2) rt[31:0] = 32'($urandom_range(1, 4096));
            rl = (k == 1);
            send(rh, rm, rt, rl, model_f(rh, rm, rt, rl), 1'b0);
            receive("random", k, 1'b1);
        end

        // Reset in the middle of a job
        send(param_h(), {512'd0, m0}, 128'd3, 1'b1, digest_to_h(ABC_DIG), 1'b0);
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 512'(out_valid), 512'(1'b0));
        check_eq("midrst_in_ready", 512'(in_ready), 512'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_release_ready", 512'(in_ready), 512'(1'b1));
        check_eq("midrst_release_valid", 512'(out_valid), 512'(1'b0));
        exp_q.delete();
        send(param_h(), {512'd0, m0}, 128'd3, 1'b1, digest_to_h(ABC_DIG), 1'b0);
        receive("abc_after_rst", 0, 1'b1);

        // Back-to-back: second job held valid across the first handshake
        for (int w = 0; w < 32; w++) rm[w*32 +: 32] = $urandom();
        send(param_h(), {512'd0, m0}, 128'd3, 1'b1, digest_to_h(ABC_DIG), 1'b1);
        h_in = param_h();
        m    = rm;
        t    = 128'd128;
        last = 1'b0;
        receive("b2b_first", 0, 1'b1);
        check_eq("b2b_ready_after_hs", 512'(in_ready), 512'(1'b1));
        send(param_h(), rm, 128'd128, 1'b0, model_f(param_h(), rm, 128'd128, 1'b0), 1'b0);
        check_eq("b2b_accept_cycle", 512'(accept_cyc), 512'(cyc));
        receive("b2b_second", 0, 1'b1);

`ifdef COMPRESS_ABORT_EN
        // Abort in IDLE does nothing; abort mid-job returns to IDLE silently
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_idle_ready", 512'(in_ready), 512'(1'b1));
        send(param_h(), 1024'd0, 128'd0, 1'b1, digest_to_h(EMPTY_DIG), 1'b0);
        repeat (49) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_out_valid", 512'(out_valid), 512'(1'b0));
        check_eq("abort_in_ready", 512'(in_ready), 512'(1'b1));
        exp_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check_eq("abort_no_output", 512'(seen), 512'(1'b0));
        send(param_h(), {512'd0, m0}, 128'd3, 1'b1, digest_to_h(ABC_DIG), 1'b0);
        receive("abc_after_abort", 0, 1'b1);
`endif

        check_eq("scoreboard_empty", 512'(exp_q.size()), 512'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
